// File: rtl/mul_issue_scheduler_pkg.sv
// Shared types and constants for the MUL/MULH issue scheduler slice.
package mul_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic        OP_MUL   = 1'b0;
    localparam logic        OP_MULH  = 1'b1;
    localparam int unsigned TAG_NONE = 0;

    function automatic logic [31:0] sel_half(input logic op, input logic [31:0] lo,
                                             input logic [31:0] hi);
        return (op == OP_MULH) ? hi : (op == OP_MUL) ? lo : '0;
    endfunction

endpackage

// File: rtl/mul_rs_entry.sv
// One reservation-station entry with CDB snoop; MUL_RS_BYPASS_EN enables
// same-cycle capture of a broadcast matching an allocating operand.
module mul_rs_entry
    import mul_issue_scheduler_pkg::*;
#(
    parameter int unsigned TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_alloc,
    input  logic            i_op,
    input  logic [TAGW-1:0] i_tag,
    input  logic [31:0]     i_vj,
    input  logic [31:0]     i_vk,
    input  logic [TAGW-1:0] i_qj,
    input  logic [TAGW-1:0] i_qk,
    input  logic            i_snp_valid,
    input  logic [TAGW-1:0] i_snp_tag,
    input  logic [31:0]     i_snp_data,
    input  logic            i_issue,
    input  logic            i_free,
    output logic            o_busy,
    output logic            o_ready,
    output logic            o_op,
    output logic [TAGW-1:0] o_tag,
    output logic [31:0]     o_vj,
    output logic [31:0]     o_vk
);

    logic            r_busy, r_issued, r_op;
    logic [TAGW-1:0] r_tag, r_qj, r_qk;
    logic [31:0]     r_vj, r_vk;
    logic            w_hit_j, w_hit_k, w_byp_j, w_byp_k;

    assign w_hit_j = r_busy && (r_qj != TAGW'(TAG_NONE)) && i_snp_valid && (r_qj == i_snp_tag);
    assign w_hit_k = r_busy && (r_qk != TAGW'(TAG_NONE)) && i_snp_valid && (r_qk == i_snp_tag);

`ifdef MUL_RS_BYPASS_EN
    assign w_byp_j = i_snp_valid && (i_qj != TAGW'(TAG_NONE)) && (i_qj == i_snp_tag);
    assign w_byp_k = i_snp_valid && (i_qk != TAGW'(TAG_NONE)) && (i_qk == i_snp_tag);
`else
    assign w_byp_j = 1'b0;
    assign w_byp_k = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_issued <= 1'b0;
            r_op     <= 1'b0;
            r_tag    <= '0;
            r_qj     <= '0;
            r_qk     <= '0;
            r_vj     <= '0;
            r_vk     <= '0;
        end else if (i_alloc) begin
            r_busy   <= 1'b1;
            r_issued <= 1'b0;
            r_op     <= i_op;
            r_tag    <= i_tag;
            r_vj     <= w_byp_j ? i_snp_data : i_vj;
            r_vk     <= w_byp_k ? i_snp_data : i_vk;
            r_qj     <= w_byp_j ? '0 : i_qj;
            r_qk     <= w_byp_k ? '0 : i_qk;
        end else begin
            if (i_free) begin
                r_busy   <= 1'b0;
                r_issued <= 1'b0;
            end else if (i_issue) begin
                r_issued <= 1'b1;
            end
            if (w_hit_j) begin
                r_vj <= i_snp_data;
                r_qj <= '0;
            end
            if (w_hit_k) begin
                r_vk <= i_snp_data;
                r_qk <= '0;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy && !r_issued && (r_qj == TAGW'(TAG_NONE)) && (r_qk == TAGW'(TAG_NONE));
    assign o_op    = r_op;
    assign o_tag   = r_tag;
    assign o_vj    = r_vj;
    assign o_vk    = r_vk;

endmodule

// File: rtl/mul_issue_scheduler.sv
// MUL/MULH reservation station and single-issue controller in front of a
// fixed-latency multiplier; results are offered back on the CDB.
module mul_issue_scheduler
    import mul_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_valid,
    input  logic            alloc_op,
    input  logic [TAGW-1:0] alloc_tag,
    input  logic [31:0]     alloc_vj,
    input  logic [31:0]     alloc_vk,
    input  logic [TAGW-1:0] alloc_qj,
    input  logic [TAGW-1:0] alloc_qk,
    output logic            rs_full,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    output logic            mul_start,
    output logic [31:0]     mul_srca,
    output logic [31:0]     mul_srcb,
    output logic [TAGW-1:0] mul_tag,
    input  logic            mul_result_valid,
    input  logic [31:0]     mul_lo,
    input  logic [31:0]     mul_hi,
    output logic            cdb_req,
    output logic [TAGW-1:0] cdb_req_tag,
    output logic [31:0]     cdb_req_data,
    input  logic            cdb_grant
);

    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          r_state;
    logic [IDXW-1:0] r_sel;
    logic            r_op, r_rs_full, r_mul_start, r_cdb_req;
    logic [31:0]     r_mul_srca, r_mul_srcb, r_cdb_req_data;
    logic [TAGW-1:0] r_mul_tag, r_cdb_req_tag;

    logic [DEPTH-1:0] w_busy, w_ready, w_op, w_alloc, w_issue, w_free;
    logic [TAGW-1:0]  w_tag [DEPTH];
    logic [31:0]      w_vj  [DEPTH];
    logic [31:0]      w_vk  [DEPTH];
    logic             w_free_found, w_rdy_found, w_alloc_go, w_grant;
    logic [IDXW-1:0]  w_free_idx, w_rdy_idx;
    logic             w_snp_valid;
    logic [TAGW-1:0]  w_snp_tag;
    logic [31:0]      w_snp_data;

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDXW'(i);
            end
            if (w_ready[i] && !w_rdy_found) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = IDXW'(i);
            end
        end
    end

    // rs_full lags the busy vector by a cycle, so also require a free slot
    assign w_alloc_go = alloc_valid && !r_rs_full && w_free_found;
    assign w_grant    = (r_state == WB) && cdb_grant;

    // Our own granted result is snooped alongside the external bus
    assign w_snp_valid = cdb_valid || w_grant;
    assign w_snp_tag   = w_grant ? r_cdb_req_tag  : cdb_tag;
    assign w_snp_data  = w_grant ? r_cdb_req_data : cdb_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_alloc[gi] = w_alloc_go && (w_free_idx == IDXW'(gi));
        assign w_issue[gi] = (r_state == IDLE) && w_rdy_found && (w_rdy_idx == IDXW'(gi));
        assign w_free[gi]  = w_grant && (r_sel == IDXW'(gi));

        mul_rs_entry #(.TAGW(TAGW)) u_entry (
            .clk         (clk),
            .reset       (reset),
            .i_alloc     (w_alloc[gi]),
            .i_op        (alloc_op),
            .i_tag       (alloc_tag),
            .i_vj        (alloc_vj),
            .i_vk        (alloc_vk),
            .i_qj        (alloc_qj),
            .i_qk        (alloc_qk),
            .i_snp_valid (w_snp_valid),
            .i_snp_tag   (w_snp_tag),
            .i_snp_data  (w_snp_data),
            .i_issue     (w_issue[gi]),
            .i_free      (w_free[gi]),
            .o_busy      (w_busy[gi]),
            .o_ready     (w_ready[gi]),
            .o_op        (w_op[gi]),
            .o_tag       (w_tag[gi]),
            .o_vj        (w_vj[gi]),
            .o_vk        (w_vk[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_op           <= 1'b0;
            r_rs_full      <= 1'b0;
            r_mul_start    <= 1'b0;
            r_mul_srca     <= '0;
            r_mul_srcb     <= '0;
            r_mul_tag      <= '0;
            r_cdb_req      <= 1'b0;
            r_cdb_req_tag  <= '0;
            r_cdb_req_data <= '0;
        end else begin
            r_rs_full   <= &w_busy;
            r_mul_start <= 1'b0;
            case (r_state)
                IDLE: if (w_rdy_found) begin
                    r_sel       <= w_rdy_idx;
                    r_op        <= w_op[w_rdy_idx];
                    r_mul_start <= 1'b1;
                    r_mul_srca  <= w_vj[w_rdy_idx];
                    r_mul_srcb  <= w_vk[w_rdy_idx];
                    r_mul_tag   <= w_tag[w_rdy_idx];
                    r_state     <= ISSUE;
                end
                ISSUE: r_state <= WAIT;
                WAIT: if (mul_result_valid) begin
                    r_cdb_req_data <= sel_half(r_op, mul_lo, mul_hi);
                    r_cdb_req_tag  <= r_mul_tag;
                    r_cdb_req      <= 1'b1;
                    r_state        <= WB;
                end
                WB: if (cdb_grant) begin
                    r_cdb_req <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rs_full      = r_rs_full;
    assign mul_start    = r_mul_start;
    assign mul_srca     = r_mul_srca;
    assign mul_srcb     = r_mul_srcb;
    assign mul_tag      = r_mul_tag;
    assign cdb_req      = r_cdb_req;
    assign cdb_req_tag  = r_cdb_req_tag;
    assign cdb_req_data = r_cdb_req_data;

endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Self-checking bench for mul_issue_scheduler: directed scenarios plus a
// randomized run against a tag-indexed reservation-station model.
module tb_mul_issue_scheduler;
    import mul_issue_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    logic            clk, reset;
    logic            alloc_valid, alloc_op;
    logic [TAGW-1:0] alloc_tag, alloc_qj, alloc_qk;
    logic [31:0]     alloc_vj, alloc_vk;
    logic            rs_full;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tag;
    logic [31:0]     cdb_data;
    logic            mul_start;
    logic [31:0]     mul_srca, mul_srcb;
    logic [TAGW-1:0] mul_tag;
    logic            mul_result_valid;
    logic [31:0]     mul_lo, mul_hi;
    logic            cdb_req;
    logic [TAGW-1:0] cdb_req_tag;
    logic [31:0]     cdb_req_data;
    logic            cdb_grant;

    int checks   = 0;
    int failures = 0;

    mul_issue_scheduler #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_valid      (alloc_valid),
        .alloc_op         (alloc_op),
        .alloc_tag        (alloc_tag),
        .alloc_vj         (alloc_vj),
        .alloc_vk         (alloc_vk),
        .alloc_qj         (alloc_qj),
        .alloc_qk         (alloc_qk),
        .rs_full          (rs_full),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .mul_start        (mul_start),
        .mul_srca         (mul_srca),
        .mul_srcb         (mul_srcb),
        .mul_tag          (mul_tag),
        .mul_result_valid (mul_result_valid),
        .mul_lo           (mul_lo),
        .mul_hi           (mul_hi),
        .cdb_req          (cdb_req),
        .cdb_req_tag      (cdb_req_tag),
        .cdb_req_data     (cdb_req_data),
        .cdb_grant        (cdb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return op ? p[63:32] : p[31:0];
    endfunction

    // 33-cycle signed multiplier; reset by the same signal as the scheduler
    initial begin
        logic [63:0] prod;
        logic [31:0] a, b;
        int cnt;
        cnt = 0;
        mul_result_valid = 1'b0;
        mul_lo = '0;
        mul_hi = '0;
        forever begin
            @(negedge clk);
            mul_result_valid = 1'b0;
            if (!reset) begin
                cnt = 0;
            end else begin
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                        mul_lo = prod[31:0];
                        mul_hi = prod[63:32];
                        mul_result_valid = 1'b1;
                    end
                end
                if (mul_start === 1'b1) begin
                    a = mul_srca;
                    b = mul_srcb;
                    cnt = 33;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_alloc(input logic op, input logic [TAGW-1:0] tag, input logic [31:0] vj,
                            input logic [31:0] vk, input logic [TAGW-1:0] qj, input logic [TAGW-1:0] qk);
        alloc_valid = 1'b1;
        alloc_op = op;
        alloc_tag = tag;
        alloc_vj = vj;
        alloc_vk = vk;
        alloc_qj = qj;
        alloc_qk = qk;
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic wait_req(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (cdb_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_start(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (mul_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_grant();
        cdb_grant = 1'b1;
        @(negedge clk);
        cdb_grant = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rs_full, mul_start, cdb_req} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected 000", {rs_full, mul_start, cdb_req});
        end
        checks++;
        if ({mul_srca, mul_srcb, mul_tag, cdb_req_tag, cdb_req_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all 0",
                     mul_srca, mul_srcb, mul_tag, cdb_req_tag, cdb_req_data);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_mul_basic();
        bit ok;
        do_alloc(OP_MUL, 4'd3, 32'd7, 32'hFFFF_FFFD, 4'd0, 4'd0);
        tick();
        checks++;
        if (mul_start !== 1'b1 || mul_srca !== 32'd7 || mul_srcb !== 32'hFFFF_FFFD || mul_tag !== 4'd3) begin
            failures++;
            $display("FAIL mul_issue: got start=%b a=%h b=%h tag=%h expected 1/00000007/fffffffd/3",
                     mul_start, mul_srca, mul_srcb, mul_tag);
        end
        tick();
        checks++;
        if (mul_start !== 1'b0 || mul_srca !== 32'd7 || mul_tag !== 4'd3) begin
            failures++;
            $display("FAIL mul_pulse: got start=%b a=%h tag=%h expected 0/00000007/3", mul_start, mul_srca, mul_tag);
        end
        wait_req(80, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd3 || cdb_req_data !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mul_cdb: got req=%b tag=%h data=%h expected 1/3/ffffffeb", ok, cdb_req_tag, cdb_req_data);
        end
        pulse_grant();
        checks++;
        if (cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL mul_release: got cdb_req=%b expected 0", cdb_req);
        end
    endtask

    task automatic test_mulh();
        bit ok;
        do_alloc(OP_MULH, 4'd4, 32'h8000_0000, 32'd2, 4'd0, 4'd0);
        wait_req(80, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd4 || cdb_req_data !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mulh_cdb: got req=%b tag=%h data=%h expected 1/4/ffffffff", ok, cdb_req_tag, cdb_req_data);
        end
        pulse_grant();
    endtask

    task automatic test_forward();
        bit ok;
        bit early;
        early = 1'b0;
        do_alloc(OP_MUL, 4'd6, 32'd0, 32'd4, 4'd5, 4'd0);
        for (int i = 0; i < 4; i++) begin
            early |= (mul_start === 1'b1);
            tick();
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL fwd_wait: got mul_start=1 expected 0 while qj pending");
        end
        cdb_valid = 1'b1;
        cdb_tag = 4'd5;
        cdb_data = 32'd9;
        tick();
        cdb_valid = 1'b0;
        tick();
        checks++;
        if (mul_start !== 1'b1 || mul_srca !== 32'd9 || mul_srcb !== 32'd4 || mul_tag !== 4'd6) begin
            failures++;
            $display("FAIL fwd_issue: got start=%b a=%h b=%h tag=%h expected 1/00000009/00000004/6",
                     mul_start, mul_srca, mul_srcb, mul_tag);
        end
        wait_req(80, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd6 || cdb_req_data !== 32'd36) begin
            failures++;
            $display("FAIL fwd_cdb: got req=%b tag=%h data=%h expected 1/6/00000024", ok, cdb_req_tag, cdb_req_data);
        end
        pulse_grant();
    endtask

    task automatic test_full();
        bit ok;
        logic [15:0] seen;
        logic [TAGW-1:0] t;
        seen = '0;
        for (int i = 1; i <= 4; i++) do_alloc(OP_MUL, TAGW'(i), 32'(i), 32'd10, 4'd0, 4'd0);
        tick();
        checks++;
        if (rs_full !== 1'b1) begin
            failures++;
            $display("FAIL full_set: got rs_full=%b expected 1", rs_full);
        end
        do_alloc(OP_MUL, 4'd7, 32'd7, 32'd10, 4'd0, 4'd0);
        wait_req(120, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd1 || cdb_req_data !== 32'd10) begin
            failures++;
            $display("FAIL full_first: got req=%b tag=%h data=%h expected 1/1/0000000a", ok, cdb_req_tag, cdb_req_data);
        end
        pulse_grant();
        checks++;
        if (rs_full !== 1'b1) begin
            failures++;
            $display("FAIL full_lag: got rs_full=%b expected 1 in the cycle of the free", rs_full);
        end
        tick();
        checks++;
        if (rs_full !== 1'b0) begin
            failures++;
            $display("FAIL full_clear: got rs_full=%b expected 0", rs_full);
        end
        do_alloc(OP_MUL, 4'd5, 32'd5, 32'd10, 4'd0, 4'd0);
        for (int n = 0; n < 4; n++) begin
            wait_req(120, ok);
            t = cdb_req_tag;
            checks++;
            if (!ok || !(t inside {4'd2, 4'd3, 4'd4, 4'd5}) || seen[t] || cdb_req_data !== 32'(t) * 32'd10) begin
                failures++;
                $display("FAIL full_drain: got req=%b tag=%h data=%h expected a new tag in {2,3,4,5} with data tag*10",
                         ok, t, cdb_req_data);
            end
            if (ok) seen[t] = 1'b1;
            pulse_grant();
        end
        repeat (45) tick();
        checks++;
        if (seen !== 16'h003C || cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL full_set_tags: got seen=%h req=%b expected 003c/0", seen, cdb_req);
        end
    endtask

    task automatic test_hold_grant();
        bit ok;
        do_alloc(OP_MUL, 4'd8, 32'd123, 32'd456, 4'd0, 4'd0);
        do_alloc(OP_MUL, 4'd9, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 4'd0, 4'd0);
        wait_req(80, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd8 || cdb_req_data !== 32'd56088) begin
            failures++;
            $display("FAIL hold_first: got req=%b tag=%h data=%h expected 1/8/0000db18", ok, cdb_req_tag, cdb_req_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (cdb_req !== 1'b1 || cdb_req_tag !== 4'd8 || cdb_req_data !== 32'd56088 || mul_start !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: got req=%b tag=%h data=%h start=%b expected 1/8/0000db18/0",
                         i, cdb_req, cdb_req_tag, cdb_req_data, mul_start);
            end
        end
        pulse_grant();
        wait_start(10, ok);
        checks++;
        if (!ok || mul_tag !== 4'd9) begin
            failures++;
            $display("FAIL hold_next_issue: got start=%b tag=%h expected 1/9", ok, mul_tag);
        end
        wait_req(80, ok);
        checks++;
        if (!ok || cdb_req_tag !== 4'd9 || cdb_req_data !== 32'd30) begin
            failures++;
            $display("FAIL hold_second: got req=%b tag=%h data=%h expected 1/9/0000001e", ok, cdb_req_tag, cdb_req_data);
        end
        pulse_grant();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw;
        saw = 1'b0;
        do_alloc(OP_MUL, 4'd10, 32'd3, 32'd3, 4'd0, 4'd0);
        wait_start(10, ok);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (!ok || {rs_full, mul_start, cdb_req} !== 3'b000 || {mul_srca, mul_srcb, mul_tag, cdb_req_tag, cdb_req_data} !== '0
            || dut.r_state !== IDLE) begin
            failures++;
            $display("FAIL rst_mid: got started=%b ctl=%b a=%h b=%h tag=%h rtag=%h rdata=%h state=%0d expected 1/000/all 0/IDLE",
                     ok, {rs_full, mul_start, cdb_req}, mul_srca, mul_srcb, mul_tag, cdb_req_tag, cdb_req_data, dut.r_state);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            saw |= (cdb_req !== 1'b0) || (mul_start !== 1'b0);
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL rst_abandon: got activity after reset expected no mul_start/cdb_req");
        end
    endtask

    task automatic test_random();
        bit              m_live [16];
        logic            m_op   [16];
        logic [31:0]     m_vj   [16];
        logic [31:0]     m_vk   [16];
        logic [TAGW-1:0] m_qj   [16];
        logic [TAGW-1:0] m_qk   [16];
        int              live_cnt, allocated, retired, cyc;
        logic [TAGW-1:0] t, pj, pk;
        logic [31:0]     exp, vj, vk;
        logic            op;
        localparam int NOPS = 16;
        live_cnt = 0;
        allocated = 0;
        retired = 0;
        for (int i = 0; i < 16; i++) begin
            m_live[i] = 1'b0;
            m_op[i] = 1'b0;
            m_vj[i] = '0;
            m_vk[i] = '0;
            m_qj[i] = '0;
            m_qk[i] = '0;
        end
        for (cyc = 0; cyc < 6000 && retired < NOPS; cyc++) begin
            if (mul_start === 1'b1) begin
                t = mul_tag;
                checks++;
                if (!m_live[t] || m_qj[t] != 0 || m_qk[t] != 0 || mul_srca !== m_vj[t] || mul_srcb !== m_vk[t]) begin
                    failures++;
                    $display("FAIL rnd_issue: got tag=%h a=%h b=%h expected a ready live op with a=%h b=%h",
                             t, mul_srca, mul_srcb, m_vj[t], m_vk[t]);
                end
            end
            cdb_grant = 1'b0;
            alloc_valid = 1'b0;
            if (cdb_req === 1'b1 && $urandom_range(0, 3) != 0) begin
                t = cdb_req_tag;
                exp = ref_mul(m_op[t], m_vj[t], m_vk[t]);
                checks++;
                if (!m_live[t] || cdb_req_data !== exp) begin
                    failures++;
                    $display("FAIL rnd_cdb: got tag=%h data=%h expected live tag with data=%h", t, cdb_req_data, exp);
                end
                cdb_grant = 1'b1;
                if (m_live[t]) begin
                    m_live[t] = 1'b0;
                    live_cnt--;
                end
                retired++;
                for (int j = 1; j < 16; j++) begin
                    if (m_live[j] && m_qj[j] == t) begin m_vj[j] = exp; m_qj[j] = '0; end
                    if (m_live[j] && m_qk[j] == t) begin m_vk[j] = exp; m_qk[j] = '0; end
                end
            end else if (allocated < NOPS && live_cnt < DEPTH && rs_full === 1'b0 && $urandom_range(0, 1) == 1) begin
                do t = TAGW'($urandom_range(1, 15)); while (m_live[t]);
                op = 1'($urandom_range(0, 1));
                vj = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
                vk = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50));
                pj = '0;
                pk = '0;
                for (int j = 1; j < 16; j++) begin
                    if (m_live[j] && $urandom_range(0, 2) == 0) pj = TAGW'(j);
                    if (m_live[j] && $urandom_range(0, 3) == 0) pk = TAGW'(j);
                end
                alloc_valid = 1'b1;
                alloc_op = op;
                alloc_tag = t;
                alloc_vj = vj;
                alloc_vk = vk;
                alloc_qj = pj;
                alloc_qk = pk;
                m_live[t] = 1'b1;
                m_op[t] = op;
                m_vj[t] = vj;
                m_vk[t] = vk;
                m_qj[t] = pj;
                m_qk[t] = pk;
                live_cnt++;
                allocated++;
            end
            tick();
        end
        cdb_grant = 1'b0;
        alloc_valid = 1'b0;
        checks++;
        if (retired != NOPS) begin
            failures++;
            $display("FAIL rnd_complete: got %0d retired expected %0d", retired, NOPS);
        end
    endtask

    initial begin
        reset = 1'b0;
        alloc_valid = 1'b0;
        alloc_op = 1'b0;
        alloc_tag = '0;
        alloc_vj = '0;
        alloc_vk = '0;
        alloc_qj = '0;
        alloc_qk = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        cdb_grant = 1'b0;
        tick();
        test_reset();
        test_mul_basic();
        test_mulh();
        test_forward();
        test_full();
        test_hold_grant();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
